// File: rtl/signed_acc_pkg.sv
// signed_acc_pkg: FSM state type and saturation limits
// shared by the signed frame accumulator.
package signed_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Largest positive value of a w-bit signed number.
  function automatic longint sat_max(int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit signed number.
  function automatic longint sat_min(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/signed_add_ovf.sv
// signed_add_ovf: combinational WIDTH-bit two's-complement adder.
// Ports: a, b in; sum (wrapped), overflow (signed overflow) out.
module signed_add_ovf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  assign sum = a + b;

  // Equal operand signs with a flipped result sign.
  assign overflow = (a[WIDTH-1] == b[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/signed_acc_n.sv
// signed_acc_n: sums COUNT signed samples per frame and holds the
// result (sum, sticky overflow) until out_valid/out_ready handshake.
// Ports: clk, rst_n (sync, active-low), clear (sync abort),
//   in_data/in_valid/in_ready sample input,
//   sum/overflow/out_valid/out_ready result output.
// Build option: define SIGNED_ACC_SAT_EN to clamp overflowing adds
//   to the signed extremes instead of wrapping.
module signed_acc_n
  import signed_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(COUNT);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             done;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(COUNT - 1));
  assign done   = out_valid && out_ready;

  signed_add_ovf #(
    .WIDTH(WIDTH)
  ) u_add (
    .a       (acc),
    .b       (in_data),
    .sum     (add_sum),
    .overflow(add_ovf)
  );

`ifdef SIGNED_ACC_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  // Overflow direction follows the shared operand sign.
  always_comb begin
    acc_nx = add_sum;
    if (add_ovf) begin
      acc_nx = acc[WIDTH-1] ? SMIN : SMAX;
    end
  end
`else
  assign acc_nx = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ACCUM;
      end
      ACCUM: begin
        if (accept && last) state_nx = HOLD;
      end
      HOLD: begin
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (done) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_nx;
      ovf <= ovf | add_ovf;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign sum      = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_signed_acc_n.sv
// tb_signed_acc_n: directed vector bench for signed_acc_n
// at WIDTH=4, COUNT=2, for both wrap and saturating builds.
module tb_signed_acc_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sum;
  logic       overflow;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_acc_n #(
    .WIDTH(4),
    .COUNT(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .overflow (overflow),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] es;
    logic       eo;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_frame(logic [3:0] a, logic [3:0] b,
                           logic [3:0] es, logic eo);
    in_valid = 1'b1;
    in_data  = a;
    chk("in_ready_first", 32'(in_ready), 1);
    tick();
    chk("no_valid_mid", 32'(out_valid), 0);
    in_data = b;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    chk("out_valid", 32'(out_valid), 1);
    chk("sum", 32'(sum), 32'(es));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("in_ready_hold", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_sum", 32'(sum), 0);
    chk("idle_ovf", 32'(overflow), 0);
    chk("idle_ready", 32'(in_ready), 1);
  endtask

  initial begin
`ifdef SIGNED_ACC_SAT_EN
    vecs[0] = '{4'd2,  4'd3,  4'h5, 1'b0};
    vecs[1] = '{4'd6,  4'd5,  4'h7, 1'b1};
    vecs[2] = '{4'hA,  4'hC,  4'h8, 1'b1};
    vecs[3] = '{4'hB,  4'hD,  4'h8, 1'b0};
    vecs[4] = '{4'd7,  4'd1,  4'h7, 1'b1};
    vecs[5] = '{4'h8,  4'hF,  4'h8, 1'b1};
`else
    vecs[0] = '{4'd2,  4'd3,  4'h5, 1'b0};
    vecs[1] = '{4'd6,  4'd5,  4'hB, 1'b1};
    vecs[2] = '{4'hA,  4'hC,  4'h6, 1'b1};
    vecs[3] = '{4'hB,  4'hD,  4'h8, 1'b0};
    vecs[4] = '{4'd7,  4'd1,  4'h8, 1'b1};
    vecs[5] = '{4'h8,  4'hF,  4'h7, 1'b1};
`endif
    vecs[6] = '{4'hF,  4'd1,  4'h0, 1'b0};
    vecs[7] = '{4'd7,  4'h8,  4'hF, 1'b0};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_ovf", 32'(overflow), 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].a, vecs[i].b, vecs[i].es, vecs[i].eo);
    end

    // Result held while consumer stalls; X data ignored.
    in_valid = 1'b1;
    in_data  = 4'd2;
    tick();
    in_data = 4'd3;
    tick();
    in_data = 'x;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sum", 32'(sum), 5);
      chk("stall_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("rel_ready", 32'(in_ready), 1);
    chk("rel_valid", 32'(out_valid), 0);
    chk("rel_sum", 32'(sum), 0);

    // Clear aborts a partial frame, beating an accept.
    in_valid = 1'b1;
    in_data  = 4'd6;
    tick();
    clear   = 1'b1;
    in_data = 4'd3;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_sum", 32'(sum), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ready", 32'(in_ready), 1);
    run_frame(4'd1, 4'd1, 4'h2, 1'b0);

    // Clear discards a held result despite out_ready.
    in_valid = 1'b1;
    in_data  = 4'd6;
    tick();
    in_data = 4'd5;
    tick();
    in_valid  = 1'b0;
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clrh_valid", 32'(out_valid), 0);
    chk("clrh_sum", 32'(sum), 0);
    chk("clrh_ovf", 32'(overflow), 0);

    // Reset mid-frame, with clear also high.
    in_valid = 1'b1;
    in_data  = 4'd5;
    tick();
    rst_n = 1'b0;
    clear = 1'b1;
    tick();
    rst_n    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("mrst_sum", 32'(sum), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    run_frame(4'd1, 4'd1, 4'h2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_acc_n.md
SIGNED_ACC_N -- requirements
Module: signed_acc_n

Interface
REQ-001 Parameter WIDTH, default 8, signed two's-complement data width in bits; legal values are 2 or more.
REQ-002 Parameter COUNT, default 4, number of samples summed per frame; legal values are 2 or more.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  synchronous frame abort.
REQ-006 in_data  input  WIDTH  signed sample.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 sum  output  WIDTH  signed frame result.
REQ-010 overflow  output  1  sticky signed overflow for the presented frame.
REQ-011 out_valid  output  1  sum and overflow are valid.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-014 A sample SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-015 Each accepted sample SHALL be added to the WIDTH-bit accumulator, with no added pipeline stage; the first sample of a frame adds to 0.
REQ-016 Per-add overflow SHALL be asserted when both operands have equal sign bits and the sum's sign differs; overflow SHALL be OR-accumulated across the frame.
REQ-017 The sample counter SHALL count 0 to COUNT-1 and wrap to 0 when the COUNT-th sample is accepted.
REQ-018 Transitions:
- IDLE to ACCUM on the first accept.
- ACCUM to HOLD on the COUNT-th accept.
- HOLD to IDLE when out_valid and out_ready are both 1.
REQ-019 out_valid SHALL be 1 exactly while in HOLD, starting the cycle after the COUNT-th accept (latency 1); sum and overflow SHALL be stable throughout HOLD.
REQ-020 On the HOLD-to-IDLE transition, the accumulator, overflow and counter SHALL be 0 in the next cycle.
REQ-021 With out_ready held 0, the block SHALL remain in HOLD indefinitely with no input accepted.
REQ-022 clear=1 SHALL force the following next-cycle state: IDLE, accumulator 0, overflow 0, counter 0, out_valid 0.
REQ-023 clear SHALL take priority over a simultaneous accept or output handshake, and SHALL discard any result being held.
REQ-024 in_valid with X on in_data while in_ready is 0 SHALL NOT affect state.

Reset
REQ-025 rst_n=0 at a rising clk edge SHALL force: state IDLE, sum 0, overflow 0, out_valid 0, counter 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset mid-frame or in HOLD SHALL discard all partial and held results.
REQ-028 rst_n SHALL take priority over clear.

Configuration
REQ-029 Macro SIGNED_ACC_SAT_EN defined: an overflowing add SHALL clamp to the signed extreme, positive overflow to 2^(WIDTH-1)-1 and negative overflow to -2^(WIDTH-1); later adds continue from the clamped value.
REQ-030 Macro SIGNED_ACC_SAT_EN undefined: adds SHALL wrap modulo 2^WIDTH.
REQ-031 The overflow flag behaviour SHALL be identical in both builds.

Structure
REQ-032 Package signed_acc_pkg SHALL hold the FSM state enum typedef and the saturation-limit constant functions of WIDTH.
REQ-033 Sub-module signed_add_ovf SHALL be a parametrised combinational WIDTH-bit signed adder with outputs sum and overflow, instantiated once.

Verification (WIDTH=4, COUNT=2)
REQ-034 Samples 2 then 3 -> sum=0101, overflow=0, out_valid one cycle after the 2nd accept.
REQ-035 Samples 6 then 5 -> wrap build: sum=1011, overflow=1; SIGNED_ACC_SAT_EN build: sum=0111, overflow=1.
REQ-036 Samples -6 then -4 -> wrap build: sum=0110, overflow=1; SIGNED_ACC_SAT_EN build: sum=1000, overflow=1.
REQ-037 Samples -5 then -3 -> sum=1000, overflow=0.
REQ-038 Frame 2,3 with out_ready=0 for 3 cycles -> out_valid, sum=0101 and in_ready=0 hold for 3 cycles; out_ready=1 -> IDLE with in_ready=1 the next cycle.
REQ-039 Accept 6, then clear=1 with in_valid=1 -> no accept; next frame 1,1 -> sum=0010, overflow=0.
